// File: rtl/codebook_decompress_ctrl_if.sv
// Purpose: bundles the decompressor's control, index-RAM, codebook-RAM and image-RAM signals.
// Latency: n/a (wiring only).
// Backpressure: none; the RAMs are fixed-latency synchronous-read memories.
//
// Ports (master = controller side):
//   start            in  : 1-cycle start pulse
//   busy/done/err    out : status (busy level, done pulse, sticky range error)
//   idx_addr/idx_q   out/in : index RAM read address / 24-bit read data
//   cb_addr/cb_q     out/in : codebook RAM read address {index,k} / pixel data
//   img_we/img_addr/img_d out : image RAM write port
interface codebook_decompress_ctrl_if #(
    parameter int IDX_AW = 12,
    parameter int IDX_W  = 6,
    parameter int IMG_AW = 14,
    parameter int PIX_W  = 8
);
    logic              start;
    logic              busy;
    logic              done;
    logic              err;
    logic [IDX_AW-1:0] idx_addr;
    logic [23:0]       idx_q;
    logic [IDX_W+1:0]  cb_addr;
    logic [PIX_W-1:0]  cb_q;
    logic              img_we;
    logic [IMG_AW-1:0] img_addr;
    logic [PIX_W-1:0]  img_d;

    modport master (
        input  start, idx_q, cb_q,
        output busy, done, err, idx_addr, cb_addr, img_we, img_addr, img_d
    );

    modport slave (
        output start, idx_q, cb_q,
        input  busy, done, err, idx_addr, cb_addr, img_we, img_addr, img_d
    );
endinterface

// File: rtl/codebook_decompress_ctrl.sv
// Purpose: rebuilds an image from per-2x2-block codebook indices (index RAM -> codebook RAM -> image RAM).
// Latency: 7 cycles per block, 7*NBLK cycles from first index request; done pulses one cycle after the last write.
// Backpressure: none; start is only honoured in IDLE and the RAMs are fixed one-cycle synchronous-read.
//
// Ports: clk, rst_n (async active-low), bus (codebook_decompress_ctrl_if.master):
//   start/busy/done/err, idx_addr/idx_q, cb_addr/cb_q, img_we/img_addr/img_d.
// Optional feature: define DECOMP_IDX_CHECK_EN to build the sticky out-of-range index check
// (err set when idx_q[23:IDX_W] != 0); without it err is tied low.
module codebook_decompress_ctrl #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int PIX_W = 8,
    parameter int IDX_W = 6
) (
    input  logic clk,
    input  logic rst_n,
    codebook_decompress_ctrl_if.master bus
);
    localparam int          NBLK   = (IMG_W / 2) * (IMG_H / 2);
    localparam int          IDX_AW = $clog2(NBLK);
    localparam int          IMG_AW = $clog2(IMG_W * IMG_H);
    localparam int unsigned HALF_W = IMG_W / 2;
    localparam int unsigned ROW_W  = IMG_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IDX_REQ,
        S_IDX_WAIT,
        S_CB_FETCH,
        S_CB_LAST,
        S_DONE
    } state_t;

    state_t            state;
    logic [IDX_AW-1:0] blk;
    logic [1:0]        k;
    logic [IDX_W-1:0]  idx_reg;
    logic              busy_r;
    logic              done_r;
    logic              we_r;
    logic [IDX_AW-1:0] idx_addr_r;
    logic [IDX_W+1:0]  cb_addr_r;
    logic [IMG_AW-1:0] img_addr_r;

    // Raster address of pixel kk (TL,TR,BL,BR) inside block b.
    function automatic logic [IMG_AW-1:0] pix_addr(input logic [IDX_AW-1:0] b, input logic [1:0] kk);
        int unsigned bx, by, a;
        bx = 32'(b) % HALF_W;
        by = 32'(b) / HALF_W;
        a  = (by * 2 + 32'(kk[1])) * ROW_W + bx * 2 + 32'(kk[0]);
        return a[IMG_AW-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            blk        <= '0;
            k          <= '0;
            idx_reg    <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            we_r       <= 1'b0;
            idx_addr_r <= '0;
            cb_addr_r  <= '0;
            img_addr_r <= '0;
        end else begin
            done_r <= 1'b0;
            we_r   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state      <= S_IDX_REQ;
                        blk        <= '0;
                        busy_r     <= 1'b1;
                        idx_addr_r <= '0;
                    end
                end
                S_IDX_REQ: begin
                    state <= S_IDX_WAIT;
                end
                S_IDX_WAIT: begin
                    // The first codebook address is issued straight from idx_q so that
                    // k=0 is on the bus in the first CB_FETCH cycle.
                    idx_reg   <= bus.idx_q[IDX_W-1:0];
                    cb_addr_r <= {bus.idx_q[IDX_W-1:0], 2'b00};
                    k         <= 2'd0;
                    state     <= S_CB_FETCH;
                end
                S_CB_FETCH: begin
                    // Data for fetch k returns next cycle, so the write of pixel k is
                    // scheduled for the following cycle.
                    we_r       <= 1'b1;
                    img_addr_r <= pix_addr(blk, k);
                    if (k == 2'd3) begin
                        state <= S_CB_LAST;
                    end else begin
                        k         <= k + 2'd1;
                        cb_addr_r <= {idx_reg, k + 2'd1};
                    end
                end
                S_CB_LAST: begin
                    if (blk == IDX_AW'(NBLK - 1)) begin
                        state  <= S_DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        blk        <= blk + 1'b1;
                        idx_addr_r <= blk + 1'b1;
                        state      <= S_IDX_REQ;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DECOMP_IDX_CHECK_EN
    logic err_r;

    // Sticky until reset; a new start does not clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (state == S_IDX_WAIT && (|bus.idx_q[23:IDX_W])) begin
            err_r <= 1'b1;
        end
    end

    assign bus.err = err_r;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.idx_addr = idx_addr_r;
    assign bus.cb_addr  = cb_addr_r;
    assign bus.img_we   = we_r;
    assign bus.img_addr = img_addr_r;
    // Codebook data is only valid in write cycles; gate it so img_d is 0 otherwise.
    assign bus.img_d    = we_r ? bus.cb_q : '0;
endmodule

// File: tb/tb_codebook_decompress_ctrl.sv
module tb_codebook_decompress_ctrl;
    localparam int W      = 8;
    localparam int H      = 8;
    localparam int NB     = (W / 2) * (H / 2);
    localparam int BLK_CY = 7;
`ifdef DECOMP_IDX_CHECK_EN
    localparam bit EXP_ERR = 1'b1;
`else
    localparam bit EXP_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    codebook_decompress_ctrl_if #(.IDX_AW(4), .IDX_W(6), .IMG_AW(6), .PIX_W(8)) bus ();

    codebook_decompress_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .IDX_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural synchronous-read RAMs.
    logic [23:0] idx_mem [NB];
    logic [7:0]  cb_mem  [256];
    always @(posedge clk) begin
        bus.idx_q <= idx_mem[bus.idx_addr];
        bus.cb_q  <= cb_mem[bus.cb_addr];
    end

    int nchk = 0;
    int nerr = 0;

    int   wq_a [$];
    int   wq_d [$];
    int   cb_log [256];
    int   img [W*H];
    int   done_at;
    int   n_done;

    typedef struct {
        int pix;
        int exp;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string nm, input longint act, input longint exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int outs_word();
        return 32'({bus.busy, bus.done, bus.err, bus.img_we, bus.idx_addr,
                    bus.cb_addr, bus.img_addr, bus.img_d});
    endfunction

    function automatic int exp_pix(input int b, input int k);
        int row, col;
        row = (b / (W / 2)) * 2 + k / 2;
        col = (b % (W / 2)) * 2 + k % 2;
        return row * W + col;
    endfunction

    // Caller is #1 after a posedge; cycle 0 is the start cycle.
    task automatic run_img(input bit poke);
        wq_a.delete();
        wq_d.delete();
        done_at = -1;
        n_done  = 0;
        for (int i = 0; i < 256; i++) cb_log[i] = -1;
        for (int i = 0; i < W*H; i++) img[i] = -1;
        bus.start = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (poke && (c == 20 || c == 60)) bus.start = 1'b1;
            cb_log[c] = int'(bus.cb_addr);
            if (bus.img_we) begin
                wq_a.push_back(int'(bus.img_addr));
                wq_d.push_back(int'(bus.img_d));
                img[bus.img_addr] = int'(bus.img_d);
            end
            if (bus.done) begin
                n_done++;
                if (done_at < 0) done_at = c;
                if (poke) bus.start = 1'b1;
            end
        end
        bus.start = 1'b0;
    endtask

    // Compare the whole run with the write order/timing the algorithm implies.
    task automatic check_run(input string tag);
        int mis_w, mis_cb, i, idx;
        mis_w  = 0;
        mis_cb = 0;
        for (int b = 0; b < NB; b++) begin
            idx = int'(idx_mem[b] % 64);
            for (int k = 0; k < 4; k++) begin
                i = b * 4 + k;
                if (i >= wq_a.size()) mis_w++;
                else if (wq_a[i] != exp_pix(b, k) || wq_d[i] != int'(cb_mem[idx*4+k])) mis_w++;
                if (cb_log[1 + BLK_CY*b + 2 + k] != idx*4 + k) mis_cb++;
            end
        end
        chk({tag, "_writes"}, wq_a.size(), NB*4);
        chk({tag, "_wr_mism"}, mis_w, 0);
        chk({tag, "_cb_mism"}, mis_cb, 0);
        chk({tag, "_done_at"}, done_at, BLK_CY*NB + 1);
        chk({tag, "_n_done"}, n_done, 1);
        chk({tag, "_busy_end"}, bus.busy, 0);
    endtask

    initial begin
        int cnt;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        for (int c = 0; c < 256; c++) cb_mem[c] = 8'(4*c);
        for (int c = 0; c < 256; c++) cb_mem[c] = cb_mem[c] + 8'(c % 4) - 8'(4*(c % 4)) + 8'(4*(c % 4));
        for (int c = 0; c < 64; c++) for (int k = 0; k < 4; k++) cb_mem[c*4+k] = 8'(4*c + k);
        for (int b = 0; b < NB; b++) idx_mem[b] = 24'(b % 64);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", outs_word(), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_outs", outs_word(), 0);

        // Codebook c,k = 4c+k, idx = blk%64: table of expected pixels.
        tbl[0]  = '{0, 0};   tbl[1]  = '{1, 1};   tbl[2]  = '{8, 2};   tbl[3]  = '{9, 3};
        tbl[4]  = '{6, 12};  tbl[5]  = '{7, 13};  tbl[6]  = '{14, 14}; tbl[7]  = '{15, 15};
        tbl[8]  = '{54, 60}; tbl[9]  = '{55, 61}; tbl[10] = '{62, 62}; tbl[11] = '{63, 63};
        run_img(1'b0);
        check_run("basic");
        for (int i = 0; i < 12; i++) chk($sformatf("tbl_pix%0d", tbl[i].pix), img[tbl[i].pix], tbl[i].exp);
        chk("basic_err", bus.err, 0);

        // Last block uses codeword 63.
        idx_mem[15] = 24'd63;
        run_img(1'b0);
        check_run("last");
        for (int k = 0; k < 4; k++) chk($sformatf("last_cb%0d", k), cb_log[1 + BLK_CY*15 + 2 + k], 252 + k);
        chk("last_p54", img[54], 252);
        chk("last_p55", img[55], 253);
        chk("last_p62", img[62], 254);
        chk("last_p63", img[63], 255);

        // start while busy and during DONE is ignored.
        run_img(1'b1);
        check_run("poke");

        // Reset during block 5.
        bus.start = 1'b1;
        for (int c = 1; c <= 1 + BLK_CY*5 + 3; c++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        chk("pre_rst_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_outs", outs_word(), 0);
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (bus.img_we || bus.busy) cnt++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (bus.img_we || bus.busy) cnt++;
        end
        chk("rst_no_we", cnt, 0);
        run_img(1'b0);
        check_run("after_rst");
        chk("after_rst_first", wq_a.size() > 0 ? wq_a[0] : -1, 0);

        // Out-of-range upper bits on block 0.
        idx_mem[0] = 24'h000041;
        run_img(1'b0);
        check_run("range");
        chk("range_err", bus.err, EXP_ERR);
        chk("range_p0", img[0], 4);
        chk("range_p1", img[1], 5);
        chk("range_p8", img[8], 6);
        chk("range_p9", img[9], 7);
        idx_mem[0] = 24'd0;
        run_img(1'b0);
        check_run("sticky");
        chk("sticky_err", bus.err, EXP_ERR);

        // Randomized images against the model.
        for (int r = 0; r < 3; r++) begin
            for (int b = 0; b < NB; b++) idx_mem[b] = 24'($urandom);
            for (int c = 0; c < 256; c++) cb_mem[c] = 8'($urandom);
            run_img(r == 1);
            check_run($sformatf("rand%0d", r));
            chk($sformatf("rand%0d_err", r), bus.err, EXP_ERR);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
